// File: rtl/matvec_result_serializer.sv
// Captures R signed row results on y_valid and streams them LSB-byte-first, row 0 first, over valid/ready.
// First byte is presented the cycle after capture; stalls hold data, counter and buffer while o_ready is low.
module matvec_result_serializer #(
    parameter int R   = 8,
    parameter int W_Y = 19,
    parameter int W_O = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [R*W_Y-1:0] y,
    input  logic             y_valid,
    output logic [W_O-1:0]   o_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic             o_last,
    output logic             busy,
    output logic             overflow,
    input  logic             clr_ovf
);

    localparam int NB     = (W_Y + W_O - 1) / W_O;
    localparam int NBYTES = R * NB;
    localparam int YB     = NB * W_O;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [NBYTES*W_O-1:0] r_buf;
    logic [NBYTES*W_O-1:0] w_ext;
    logic                r_ovf;
    logic                w_send;
    logic                w_hs;
    logic                w_at_last;
    logic                w_done;
    logic                w_capture;
    logic                w_drop;

    // Each row occupies NB consecutive bytes, so byte cnt of the frame sits at bit cnt*W_O.
    always_comb begin
        w_ext = '0;
        for (int r = 0; r < R; r++) begin
            w_ext[r*YB +: YB] = YB'($signed(y[r*W_Y +: W_Y]));
        end
    end

    assign w_send    = (r_state == S_SEND);
    assign w_hs      = w_send && o_ready;
    assign w_at_last = (r_cnt == CW'(NBYTES - 1));
    assign w_done    = w_hs && w_at_last;
    // A capture on the final handshake chains frames; anything else while sending is lost.
    assign w_capture = y_valid && (!w_send || w_done);
    assign w_drop    = y_valid && w_send && !w_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (y_valid) w_state_nxt = S_SEND;
            S_SEND:  if (w_done && !y_valid) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_valid  = w_send;
        busy     = w_send;
        o_last   = w_send && w_at_last;
        o_data   = w_send ? r_buf[r_cnt*W_O +: W_O] : '0;
        overflow = r_ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_buf <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_capture || w_done) begin
                r_cnt <= '0;
            end else if (w_hs) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_capture) begin
                r_buf <= w_ext;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

endmodule
